ps2_scancode_decoder: RTL and testbench

- Sits directly downstream of the PS/2 frame receiver. Consumes each 11-bit frame and its done tick, then checks start, parity and stop bits.
- Folds Set-2 prefixes (E0 extended, F0 break, E1 pause sequence) into single key events and queues them in a small FIFO for the game/display logic.
- Drives the receiver's rx_en so no frame is started while the queue is full.

---
 rtl/ps2_pkg.sv | 34 +++
 rtl/ps2_event_fifo.sv | 50 +++++
 rtl/ps2_scancode_decoder.sv | 152 +++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 Set-2 scan-code decoder.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GOT_E0,
      GOT_F0,
      GOT_E0F0,
      SKIP_E1
   } ps2_state_t;

   localparam logic [7:0] PS2_E0 = 8'hE0;
   localparam logic [7:0] PS2_F0 = 8'hF0;
   localparam logic [7:0] PS2_E1 = 8'hE1;

   localparam int unsigned E1_SKIP_LEN = 7;
   localparam int unsigned SKIP_W      = 3;
   localparam int unsigned EVENT_W     = 10;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
   } key_event_t;

   // Device-to-host control bytes: BAT ok, ack, resend, echo, errors.
   function automatic logic is_ctrl_code(input logic [7:0] b);
      case (b)
         8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: is_ctrl_code = 1'b1;
         default:                                  is_ctrl_code = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through event queue; simultaneous push/pop is legal when full.
module ps2_event_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [EVENT_W-1:0] din,
   input  logic               rd_en,
   output logic [EVENT_W-1:0] dout,
   output logic               empty,
   output logic               full
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [EVENT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic               do_wr;
   logic               do_rd;

   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));
   assign do_rd = rd_en & ~empty;
   assign do_wr = wr_en & (~full | do_rd);
   assign dout  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
         if (do_wr && !do_rd)      count <= count + CNT_W'(1);
         else if (do_rd && !do_wr) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Checks PS/2 frames, folds Set-2 prefixes into key events and queues them.
module ps2_scancode_decoder
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 200000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx_done_tick,
   input  logic [10:0] frame_in,
   output logic        rx_en,
   output logic        key_valid,
   output logic [7:0]  key_code,
   output logic        key_ext,
   output logic        key_brk,
   input  logic        key_rd,
   output logic        ctrl_tick,
   output logic [7:0]  ctrl_code,
   output logic        frame_err,
   output logic        overflow
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   ps2_state_t        state;
   logic [SKIP_W-1:0] skip_cnt;
   logic [TMO_W-1:0]  tmo_cnt;

   logic              frame_ok_c;
   logic [7:0]        byte_c;
   logic              push_c;
   key_event_t        push_ev_c;
   key_event_t        head;
   logic              fifo_empty;
   logic              fifo_full;

   assign byte_c     = frame_in[8:1];
   assign frame_ok_c = ~frame_in[0] & frame_in[10] & (^frame_in[9:1]);

   // Event to push this cycle, written at the edge that ends the tick cycle.
   always_comb begin
      push_c    = 1'b0;
      push_ev_c = '0;
      if (rx_done_tick && frame_ok_c) begin
         case (state)
            IDLE: begin
               if (byte_c != PS2_E0 && byte_c != PS2_F0 && byte_c != PS2_E1 &&
                   !is_ctrl_code(byte_c)) begin
                  push_c    = 1'b1;
                  push_ev_c = '{code: byte_c, ext: 1'b0, brk: 1'b0};
               end
            end
            GOT_E0: begin
               if (byte_c != PS2_F0) begin
                  push_c    = 1'b1;
                  push_ev_c = '{code: byte_c, ext: 1'b1, brk: 1'b0};
               end
            end
            GOT_F0: begin
               push_c    = 1'b1;
               push_ev_c = '{code: byte_c, ext: 1'b0, brk: 1'b1};
            end
            GOT_E0F0: begin
               push_c    = 1'b1;
               push_ev_c = '{code: byte_c, ext: 1'b1, brk: 1'b1};
            end
            SKIP_E1: begin
               if (skip_cnt == SKIP_W'(1)) begin
                  push_c    = 1'b1;
                  push_ev_c = '{code: PS2_E1, ext: 1'b0, brk: 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         skip_cnt  <= '0;
         tmo_cnt   <= '0;
         ctrl_tick <= 1'b0;
         ctrl_code <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         ctrl_tick <= 1'b0;
         frame_err <= 1'b0;
         if (push_c && fifo_full && !key_rd) overflow <= 1'b1;

         if (rx_done_tick) begin
            tmo_cnt <= '0;
            if (!frame_ok_c) begin
               frame_err <= 1'b1;
               state     <= IDLE;
            end else begin
               case (state)
                  IDLE: begin
                     if (byte_c == PS2_E0)      state <= GOT_E0;
                     else if (byte_c == PS2_F0) state <= GOT_F0;
                     else if (byte_c == PS2_E1) begin
                        state    <= SKIP_E1;
                        skip_cnt <= SKIP_W'(E1_SKIP_LEN);
                     end else if (is_ctrl_code(byte_c)) begin
                        ctrl_code <= byte_c;
                        ctrl_tick <= 1'b1;
                     end
                  end
                  GOT_E0:   state <= (byte_c == PS2_F0) ? GOT_E0F0 : IDLE;
                  GOT_F0:   state <= IDLE;
                  GOT_E0F0: state <= IDLE;
                  SKIP_E1: begin
                     skip_cnt <= skip_cnt - SKIP_W'(1);
                     if (skip_cnt == SKIP_W'(1)) state <= IDLE;
                  end
                  default:  state <= IDLE;
               endcase
            end
         end else if (state != IDLE) begin
            // A prefix with no follow-up byte is abandoned silently.
            if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
               state   <= IDLE;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end

   ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .wr_en (push_c),
      .din   (push_ev_c),
      .rd_en (key_rd),
      .dout  (head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

   assign rx_en     = ~fifo_full;
   assign key_valid = ~fifo_empty;
   assign key_code  = head.code;
   assign key_ext   = head.ext;
   assign key_brk   = head.brk;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_done_tick;
   logic [10:0] frame_in;
   logic        rx_en;
   logic        key_valid;
   logic [7:0]  key_code;
   logic        key_ext;
   logic        key_brk;
   logic        key_rd;
   logic        ctrl_tick;
   logic [7:0]  ctrl_code;
   logic        frame_err;
   logic        overflow;

   int ncmp = 0;
   int nerr = 0;

   ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_done_tick (rx_done_tick),
      .frame_in     (frame_in),
      .rx_en        (rx_en),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ext      (key_ext),
      .key_brk      (key_brk),
      .key_rd       (key_rd),
      .ctrl_tick    (ctrl_tick),
      .ctrl_code    (ctrl_code),
      .frame_err    (frame_err),
      .overflow     (overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Stop bit 1, odd parity (optionally corrupted), data LSB first, start 0.
   function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad);
      mk_frame = {1'b1, (~^b) ^ bad, b, 1'b0};
   endfunction

   task automatic send_frame(input logic [7:0] b, input logic bad);
      @(posedge clk); #1;
      rx_done_tick = 1'b1;
      frame_in     = mk_frame(b, bad);
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      frame_in     = '0;
   endtask

   task automatic pop_ev(output logic v, output logic [9:0] ev);
      @(negedge clk);
      v  = key_valid;
      ev = {key_code, key_ext, key_brk};
      if (v) begin
         @(posedge clk); #1 key_rd = 1'b1;
         @(posedge clk); #1 key_rd = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      ncmp++;
      if ({rx_en, key_valid, ctrl_tick, frame_err, overflow, ctrl_code} !== {5'b10000, 8'h00}) begin
         nerr++;
         $display("FAIL reset_outputs: got rx_en=%b kv=%b ct=%b fe=%b ov=%b cc=%h, want 1 0 0 0 0 00",
                  rx_en, key_valid, ctrl_tick, frame_err, overflow, ctrl_code);
      end
   endtask

   task automatic test_make_break();
      logic v; logic [9:0] ev;
      @(posedge clk); #1;
      rx_done_tick = 1'b1; frame_in = mk_frame(8'h1C, 1'b0);
      @(negedge clk);
      ncmp++;
      if (key_valid !== 1'b0) begin
         nerr++; $display("FAIL kv_during_tick: got %b want 0", key_valid);
      end
      @(posedge clk); #1;
      rx_done_tick = 1'b0; frame_in = '0;
      @(negedge clk);
      ncmp++;
      if (key_valid !== 1'b1) begin
         nerr++; $display("FAIL kv_after_tick: got %b want 1", key_valid);
      end
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h1C, 2'b00}) begin
         nerr++; $display("FAIL make_1c: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h1C, 2'b00});
      end
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h1C, 2'b01}) begin
         nerr++; $display("FAIL break_1c: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h1C, 2'b01});
      end
      @(negedge clk);
      ncmp++;
      if (key_valid !== 1'b0) begin
         nerr++; $display("FAIL make_break_drained: got kv=%b want 0", key_valid);
      end
   endtask

   task automatic test_extended();
      logic v; logic [9:0] ev;
      logic [7:0] pause_seq [8];
      pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h75, 2'b10}) begin
         nerr++; $display("FAIL ext_make: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h75, 2'b10});
      end
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h75, 2'b11}) begin
         nerr++; $display("FAIL ext_break: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h75, 2'b11});
      end
      for (int i = 0; i < 8; i++) send_frame(pause_seq[i], 1'b0);
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'hE1, 2'b00}) begin
         nerr++; $display("FAIL pause_event: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'hE1, 2'b00});
      end
      @(negedge clk);
      ncmp++;
      if (key_valid !== 1'b0) begin
         nerr++; $display("FAIL pause_single: got kv=%b want 0", key_valid);
      end
   endtask

   task automatic test_frame_err();
      logic v; logic [9:0] ev;
      send_frame(8'h1C, 1'b1);
      @(negedge clk);
      ncmp++;
      if ({frame_err, key_valid} !== 2'b10) begin
         nerr++; $display("FAIL frame_err_pulse: got fe=%b kv=%b want 1 0", frame_err, key_valid);
      end
      @(negedge clk);
      ncmp++;
      if ({frame_err, key_valid} !== 2'b00) begin
         nerr++; $display("FAIL frame_err_once: got fe=%b kv=%b want 0 0", frame_err, key_valid);
      end
      send_frame(8'hF0, 1'b0);
      send_frame(8'h33, 1'b1);
      send_frame(8'h1C, 1'b0);
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h1C, 2'b00}) begin
         nerr++; $display("FAIL err_abandons_f0: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h1C, 2'b00});
      end
   endtask

   task automatic test_timeout();
      logic v; logic [9:0] ev;
      send_frame(8'hF0, 1'b0);
      repeat (TMO - 1) @(posedge clk);
      send_frame(8'h1C, 1'b0);
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h1C, 2'b00}) begin
         nerr++; $display("FAIL timeout_f0: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h1C, 2'b00});
      end
      @(negedge clk);
      ncmp++;
      if ({key_valid, frame_err} !== 2'b00) begin
         nerr++; $display("FAIL timeout_silent: got kv=%b fe=%b want 0 0", key_valid, frame_err);
      end
   endtask

   task automatic test_ctrl();
      send_frame(8'hAA, 1'b0);
      @(negedge clk);
      ncmp++;
      if ({ctrl_tick, ctrl_code, key_valid} !== {1'b1, 8'hAA, 1'b0}) begin
         nerr++; $display("FAIL ctrl_aa: got ct=%b cc=%h kv=%b want 1 aa 0", ctrl_tick, ctrl_code, key_valid);
      end
      @(negedge clk);
      ncmp++;
      if ({ctrl_tick, ctrl_code} !== {1'b0, 8'hAA}) begin
         nerr++; $display("FAIL ctrl_hold: got ct=%b cc=%h want 0 aa", ctrl_tick, ctrl_code);
      end
      send_frame(8'hFA, 1'b0);
      @(negedge clk);
      ncmp++;
      if ({ctrl_tick, ctrl_code, key_valid} !== {1'b1, 8'hFA, 1'b0}) begin
         nerr++; $display("FAIL ctrl_fa: got ct=%b cc=%h kv=%b want 1 fa 0", ctrl_tick, ctrl_code, key_valid);
      end
   endtask

   task automatic test_back_to_back();
      logic v; logic [9:0] ev;
      logic [7:0] exp_q [4];
      exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
      send_frame(8'h11, 1'b0);
      send_frame(8'h22, 1'b0);
      send_frame(8'h33, 1'b0);
      @(negedge clk);
      ncmp++;
      if (rx_en !== 1'b1) begin
         nerr++; $display("FAIL rx_en_three: got %b want 1", rx_en);
      end
      send_frame(8'h44, 1'b0);
      @(negedge clk);
      ncmp++;
      if (rx_en !== 1'b0) begin
         nerr++; $display("FAIL rx_en_full: got %b want 0", rx_en);
      end
      send_frame(8'h55, 1'b0);
      @(negedge clk);
      ncmp++;
      if ({overflow, key_code} !== {1'b1, 8'h11}) begin
         nerr++; $display("FAIL overflow_drop: got ov=%b head=%h want 1 11", overflow, key_code);
      end
      // Pop and push in the same cycle while full.
      @(posedge clk); #1;
      key_rd = 1'b1; rx_done_tick = 1'b1; frame_in = mk_frame(8'h66, 1'b0);
      @(posedge clk); #1;
      key_rd = 1'b0; rx_done_tick = 1'b0; frame_in = '0;
      @(negedge clk);
      ncmp++;
      if ({rx_en, key_valid, key_code} !== {2'b01, 8'h22}) begin
         nerr++; $display("FAIL push_pop_full: got rx_en=%b kv=%b head=%h want 0 1 22", rx_en, key_valid, key_code);
      end
      for (int i = 0; i < 4; i++) begin
         pop_ev(v, ev);
         ncmp++;
         if ({v, ev} !== {1'b1, exp_q[i], 2'b00}) begin
            nerr++; $display("FAIL drain_%0d: got v=%b ev=%h want v=1 ev=%h", i, v, ev, {exp_q[i], 2'b00});
         end
      end
      @(negedge clk);
      ncmp++;
      if ({key_valid, overflow} !== 2'b01) begin
         nerr++; $display("FAIL drained_sticky: got kv=%b ov=%b want 0 1", key_valid, overflow);
      end
      // Reset with events queued and an E0 prefix pending.
      send_frame(8'h1C, 1'b0);
      send_frame(8'h2D, 1'b0);
      send_frame(8'hE0, 1'b0);
      do_reset();
      @(negedge clk);
      ncmp++;
      if ({key_valid, overflow, rx_en} !== 3'b001) begin
         nerr++; $display("FAIL reset_flush: got kv=%b ov=%b rx_en=%b want 0 0 1", key_valid, overflow, rx_en);
      end
      send_frame(8'h75, 1'b0);
      pop_ev(v, ev);
      ncmp++;
      if ({v, ev} !== {1'b1, 8'h75, 2'b00}) begin
         nerr++; $display("FAIL reset_clears_prefix: got v=%b ev=%h want v=1 ev=%h", v, ev, {8'h75, 2'b00});
      end
   endtask

   initial begin
      reset        = 1'b1;
      rx_done_tick = 1'b0;
      frame_in     = '0;
      key_rd       = 1'b0;
      test_reset();
      test_make_break();
      test_extended();
      test_frame_err();
      test_timeout();
      test_ctrl();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
